// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch-state encoding and reset defaults.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Control-flow request from the decoder plus the ALU zero flag.
  typedef struct packed {
    logic jump;
    logic branch;
    logic zero;
  } pc_ctrl_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation: sequential, branch and jump targets
// with jump taking priority over a taken branch.
module pc_next_logic
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       jidx,
  input  pc_ctrl_t          ctrl,
  input  logic [31:0]       signimm,
  output logic [ADDR_W-1:0] pcplus4,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] boff;
  logic [ADDR_W-1:0] btgt;
  logic [ADDR_W-1:0] jtgt;
  logic [ADDR_W-1:0] sel;

  assign pcplus4 = pc + ADDR_W'(4);
  assign boff    = ADDR_W'({signimm, 2'b00});
  assign btgt    = pcplus4 + boff;
  assign jtgt    = {pcplus4[ADDR_W-1:28], jidx, 2'b00};

  always_comb begin
    sel = pcplus4;
    if (ctrl.jump)
      sel = jtgt;
    else if (ctrl.branch && ctrl.zero)
      sel = btgt;
  end

  // Fetch addresses are always word aligned.
  assign pc_next = sel & ~ADDR_W'(3);

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, instruction register and the IDLE/REQ/EXEC fetch FSM
// driving the ready-handshake instruction-memory port.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              hold,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [31:0]       SignImm,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              instr_valid
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] pc_next;
  pc_ctrl_t          ctrl;

  assign ctrl = '{jump: Jump, branch: Branch, zero: Zero};

  pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc      (pc),
    .jidx    (instr[25:0]),
    .ctrl    (ctrl),
    .signimm (SignImm),
    .pcplus4 (PCPlus4),
    .pc_next (pc_next)
  );

  // Decoder inputs only matter in EXEC; a reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR[DATA_W-1:0];
    end else begin
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!hold) begin
            pc    <= pc_next;
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (state == ST_REQ);
  assign instr_valid = (state == ST_EXEC);
  assign imem_addr   = pc;
  assign PC          = pc;
  assign Instr       = instr;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level reference of the fetch stage.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        hold;
  logic        Jump;
  logic        Branch;
  logic        Zero;
  logic [31:0] SignImm;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;

  // Reference: PC, IR and whether a fetch is outstanding / an instruction is executing.
  logic [31:0] refPc;
  logic [31:0] refInstr;
  bit          refFetching;
  bit          refExecuting;

  fetch_pc_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .hold        (hold),
    .Jump        (Jump),
    .Branch      (Branch),
    .Zero        (Zero),
    .SignImm     (SignImm),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refNextPc(input logic [31:0] pc, input logic [31:0] ir,
                                            input bit j, input bit b, input bit z,
                                            input logic [31:0] imm);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
    if (b && z) return seq + imm * 4;
    return seq;
  endfunction

  // Drives one cycle of inputs, advances the reference at the edge, checks at the falling edge.
  task automatic applyStimulus(input bit r, input bit rdy, input logic [31:0] rdata,
                               input bit hld, input bit j, input bit b, input bit z,
                               input logic [31:0] imm);
    rst = r; imem_ready = rdy; imem_rdata = rdata; hold = hld;
    Jump = j; Branch = b; Zero = z; SignImm = imm;
    @(posedge clk);
    if (r) begin
      refPc = 32'h0; refInstr = 32'h0; refFetching = 0; refExecuting = 0;
    end else if (refExecuting) begin
      if (!hld) begin
        refPc = refNextPc(refPc, refInstr, j, b, z, imm);
        refExecuting = 0; refFetching = 1;
      end
    end else if (refFetching) begin
      if (rdy) begin
        refInstr = rdata; refFetching = 0; refExecuting = 1;
      end
    end else begin
      refFetching = 1;
    end
    @(negedge clk);
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, refFetching});
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, refExecuting});
    checkOutput("PC", PC, refPc);
    checkOutput("imem_addr", imem_addr, refPc);
    checkOutput("PCPlus4", PCPlus4, refPc + 32'd4);
    checkOutput("Instr", Instr, refInstr);
  endtask

  task automatic idleCycle(input bit rdy, input logic [31:0] rdata);
    applyStimulus(0, rdy, rdata, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; imem_ready = 0; imem_rdata = 0; hold = 0;
    Jump = 0; Branch = 0; Zero = 0; SignImm = 0;
    refPc = 0; refInstr = 0; refFetching = 0; refExecuting = 0;
    @(negedge clk);

    // Reset held three cycles, then the one-cycle gap before the first request.
    repeat (3) applyStimulus(1, 1, 32'hFFFF_FFFF, 0, 1, 1, 1, 32'h5);
    checkOutput("rstInstr", Instr, 32'h0);
    checkOutput("rstReq", {31'b0, imem_req}, 32'h0);
    idleCycle(0, 32'h0);
    checkOutput("reqAfterRelease", {31'b0, imem_req}, 32'h1);
    checkOutput("addrAfterRelease", imem_addr, 32'h0);

    // Straight-line code with memory always ready.
    for (int i = 0; i < 6; i++) idleCycle(1, 32'h0123_0000 + i);
    checkOutput("straightPC", PC, 32'h0000_000C);

    // Jump to 0x100, then beq with offset -2 taken and not taken.
    idleCycle(1, 32'h0800_0040);
    applyStimulus(0, 1, 32'h0, 0, 1, 0, 0, 32'h0);
    checkOutput("jumpTo100", PC, 32'h0000_0100);
    idleCycle(1, 32'h1000_FFFE);
    applyStimulus(0, 1, 32'h0, 0, 0, 1, 1, 32'hFFFF_FFFE);
    checkOutput("branchTaken", PC, 32'h0000_00FC);
    idleCycle(1, 32'h0);
    idleCycle(1, 32'h0);
    idleCycle(1, 32'h1000_FFFE);
    applyStimulus(0, 1, 32'h0, 0, 0, 1, 0, 32'hFFFF_FFFE);
    checkOutput("branchNotTaken", PC, 32'h0000_0104);

    // Reach 0x1000_0040 by branch, then jump and branch together: jump wins.
    idleCycle(1, 32'h0);
    applyStimulus(0, 1, 32'h0, 0, 0, 1, 1, 32'h03FF_FFCE);
    checkOutput("branchFar", PC, 32'h1000_0040);
    idleCycle(1, 32'h0800_0010);
    applyStimulus(0, 1, 32'h0, 0, 1, 1, 1, 32'hFFFF_FFFE);
    checkOutput("jumpBeatsBranch", PC, 32'h1000_0040);

    // Slow memory, then external hold while executing.
    repeat (5) idleCycle(0, 32'hBAD0_BAD0);
    checkOutput("waitReq", {31'b0, imem_req}, 32'h1);
    checkOutput("waitAddr", imem_addr, 32'h1000_0040);
    idleCycle(1, 32'h2222_3333);
    repeat (3) applyStimulus(0, 0, 32'h0, 1, $urandom_range(0, 1), 1, 1, 32'h10);
    checkOutput("holdPC", PC, 32'h1000_0040);
    checkOutput("holdInstr", Instr, 32'h2222_3333);
    checkOutput("holdValid", {31'b0, instr_valid}, 32'h1);
    idleCycle(0, 32'h0);
    checkOutput("afterHold", PC, 32'h1000_0044);

    // Reset during a fetch beats a simultaneous imem_ready.
    applyStimulus(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0);
    checkOutput("rstMidFetchInstr", Instr, 32'h0);
    checkOutput("rstMidFetchPC", PC, 32'h0);
    checkOutput("rstMidFetchReq", {31'b0, imem_req}, 32'h0);

    // Wraparound: branch back to 0xFFFF_FFFC, then step to 0.
    idleCycle(1, 32'h0);
    idleCycle(1, 32'h0);
    applyStimulus(0, 1, 32'h0, 0, 0, 1, 1, 32'hFFFF_FFFE);
    checkOutput("toTop", PC, 32'hFFFF_FFFC);
    idleCycle(1, 32'h0);
    idleCycle(1, 32'h0);
    checkOutput("wrapPC", PC, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 127)) - 64);
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 1), $urandom(),
                    $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 1), imm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
